// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: SBOX_COUNT byte S-boxes sweep the 16-byte state in STEPS cycles.
// Optional macro SUB_BYTES_SHIFTROWS_EN presents the ShiftRows of the result on out_data.
module sub_bytes_iter #(
   parameter int SBOX_COUNT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int STEPS = 16 / SBOX_COUNT;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   if (SBOX_COUNT != 1 && SBOX_COUNT != 2 && SBOX_COUNT != 4 &&
       SBOX_COUNT != 8 && SBOX_COUNT != 16) begin : g_bad_cfg
      $error("sub_bytes_iter: SBOX_COUNT must be 1, 2, 4, 8 or 16");
   end

   // Forward AES S-box, entry 0 leftmost.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [127:0]       work_q, work_d;

   // A 4-bit byte index can only address bytes 0..15.
   function automatic logic [3:0] byte_idx(input logic [CNT_W-1:0] cnt, input int lane);
      return 4'((int'(cnt) * SBOX_COUNT) + lane);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         // NOTE: the working register is reset as well, so an aborted block leaves nothing on out_data.
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      // NOTE: every target gets a default before the case, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            // Byte k sits at bit offset 8*(15-k), i.e. {~k, 3'b000} for a 4-bit k.
            for (int lane = 0; lane < SBOX_COUNT; lane++) begin
               work_d[{~byte_idx(cnt_q, lane), 3'b000} +: 8] =
                  SBOX[work_q[{~byte_idx(cnt_q, lane), 3'b000} +: 8]];
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_BUSY);
   assign out_valid = (state_q == S_DONE);

`ifdef SUB_BYTES_SHIFTROWS_EN
   // Output (row r, col c) takes substituted (row r, col (c+r)%4); byte k = 4*col + row.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign out_data[127-8*(4*c+r) -: 8] = work_q[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end
`else
   assign out_data = work_q;
`endif

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed self-checking bench for sub_bytes_iter: one SBOX_COUNT=4 instance plus a
// sweep group (1, 2, 8, 16) sharing stimulus; expected states are hand-computed.
module tb_sub_bytes_iter;

   localparam logic [127:0] VEC_A = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_B = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] ZEROS = '0;
   localparam logic [127:0] ONES  = '1;
`ifdef SUB_BYTES_SHIFTROWS_EN
   localparam logic [127:0] EXP_A = 128'h63fcac161bee28c3c4c193f54b8233ea;
   localparam logic [127:0] EXP_B = 128'h7c62f4caa7862385bb206edf3826bd46;
`else
   localparam logic [127:0] EXP_A = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [127:0] EXP_B = 128'h7c266e85a762bddfbb86f446382023ca;
`endif
   localparam logic [127:0] EXP_Z = {16{8'h63}};
   localparam logic [127:0] EXP_F = {16{8'h16}};

   localparam int SW_SC [4] = '{1, 2, 8, 16};

   logic         clk;
   logic         rst_n;

   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_data, out_data;

   logic         sw_in_valid, sw_out_ready;
   logic [127:0] sw_in_data;
   logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
   logic [127:0] sw_out_data [4];

   int n_checks = 0;
   int n_errors = 0;

   sub_bytes_iter #(.SBOX_COUNT(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_sw
      sub_bytes_iter #(.SBOX_COUNT(SW_SC[g])) u_sw (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (sw_in_valid),
         .in_ready  (sw_in_ready[g]),
         .in_data   (sw_in_data),
         .out_valid (sw_out_valid[g]),
         .out_ready (sw_out_ready),
         .out_data  (sw_out_data[g]),
         .busy      (sw_busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Accept on the main instance, count cycles to out_valid, check, then drain.
   task automatic run_main(input string tag, input logic [127:0] data, input logic [127:0] exp);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_busy"}, 128'(busy), 128'(1));
      check({tag, "_in_ready_low"}, 128'(in_ready), 128'(0));
      n = 0;
      while (n < 40 && !out_valid) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, 128'(n), 128'(4));
      check({tag, "_data"}, out_data, exp);
   endtask

   task automatic drain_main(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drain_valid"}, 128'(out_valid), 128'(0));
      check({tag, "_drain_in_ready"}, 128'(in_ready), 128'(1));
   endtask

   task automatic sweep_run(input string tag, input logic [127:0] data, input logic [127:0] exp);
      int lat [4];
      @(negedge clk);
      sw_in_valid = 1'b1;
      sw_in_data  = data;
      @(posedge clk);
      #1;
      sw_in_valid = 1'b0;
      for (int g = 0; g < 4; g++) lat[g] = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 4; g++) begin
            if (lat[g] == 0 && sw_out_valid[g]) lat[g] = n;
         end
      end
      for (int g = 0; g < 4; g++) begin
         check($sformatf("%s_sc%0d_latency", tag, SW_SC[g]), 128'(lat[g]), 128'(16 / SW_SC[g]));
         check($sformatf("%s_sc%0d_data", tag, SW_SC[g]), sw_out_data[g], exp);
      end
      @(negedge clk);
      sw_out_ready = 1'b1;
      @(posedge clk);
      #1;
      sw_out_ready = 1'b0;
      check({tag, "_drain_valid"}, 128'(sw_out_valid), 128'(0));
      check({tag, "_drain_in_ready"}, 128'(sw_in_ready), 128'(4'hf));
   endtask

   initial begin
      logic [127:0] b2b_vec [3];
      logic [127:0] b2b_exp [3];
      logic         do_acc, do_out;
      int           acc, got, t_prev;

      b2b_vec = '{VEC_A, VEC_B, ONES};
      b2b_exp = '{EXP_A, EXP_B, EXP_F};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b0;
      sw_in_valid  = 1'b0;
      sw_in_data   = '0;
      sw_out_ready = 1'b0;

      #12;
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_out_data", out_data, ZEROS);
      @(negedge clk);
      rst_n = 1'b1;

      // out_ready while nothing is pending must not disturb IDLE
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_oready_in_ready", 128'(in_ready), 128'(1));
      check("idle_oready_out_valid", 128'(out_valid), 128'(0));
      out_ready = 1'b0;

      // Known vector, then backpressure in DONE with in_valid toggling
      run_main("vec_a", VEC_A, EXP_A);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         in_data  = VEC_B ^ 128'(i);
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_valid", i), 128'(out_valid), 128'(1));
         check($sformatf("bp%0d_in_ready", i), 128'(in_ready), 128'(0));
         check($sformatf("bp%0d_data", i), out_data, EXP_A);
      end
      @(negedge clk);
      in_valid = 1'b0;
      drain_main("vec_a");
      @(posedge clk);
      #1;
      check("post_drain_single", 128'(out_valid), 128'(0));

      run_main("vec_b", VEC_B, EXP_B);
      drain_main("vec_b");

      // Reset in the middle of an SBOX_COUNT=1 block at cnt==2
      @(negedge clk);
      sw_in_valid = 1'b1;
      sw_in_data  = VEC_A;
      @(posedge clk);
      #1;
      sw_in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_busy_before_rst", 128'(sw_busy[0]), 128'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 128'(sw_in_ready[0]), 128'(1));
      check("mid_rst_out_valid", 128'(sw_out_valid[0]), 128'(0));
      check("mid_rst_busy", 128'(sw_busy[0]), 128'(0));
      check("mid_rst_out_data", sw_out_data[0], ZEROS);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst%0d_no_valid", i), 128'(sw_out_valid), 128'(0));
      end

      sweep_run("sw_zero", ZEROS, EXP_Z);
      sweep_run("sw_ones", ONES, EXP_F);

      // Back-to-back: in_valid and out_ready held high across three blocks
      acc    = 0;
      got    = 0;
      t_prev = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = b2b_vec[0];
      out_ready = 1'b1;
      for (int c = 0; c < 200 && got < 3; c++) begin
         do_acc = in_valid && in_ready;
         do_out = out_valid && out_ready;
         if (do_out) begin
            check($sformatf("b2b%0d_data", got), out_data, b2b_exp[got]);
            if (got > 0) check($sformatf("b2b%0d_spacing", got), 128'(c - t_prev), 128'(6));
            t_prev = c;
            got++;
         end
         @(posedge clk);
         #1;
         if (do_acc) begin
            acc++;
            if (acc < 3) in_data = b2b_vec[acc];
            else in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b_count", 128'(got), 128'(3));
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
